// File: rtl/fetch_if.sv
// Fetch-side bus bundle: instruction memory byte port, decode handshake and
// branch/jump redirect inputs.
interface fetch_if;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        done;

  modport master (
    output mem_addr, instr, instr_pc, instr_valid, done,
    input  mem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_addr, instr, instr_pc, instr_valid, done,
    output mem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: reads a big-endian word one byte per cycle,
// offers it to decode over valid/ready, follows redirects, parks at PC_LIMIT.
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_LIMIT = 32'd36
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam state_t RST_STATE = (RESET_PC >= PC_LIMIT) ? S_DONE : S_FETCH;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] sh_q, sh_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;

  logic [31:0] pc_inc;
  logic [31:0] redir_tgt;
  logic        hs;
  logic        last_byte;

  assign pc_inc    = pc_q + 32'd4;
  assign redir_tgt = bus.redirect_pc & ~32'd3;
  assign hs        = (state_q == S_VALID) && instr_valid_q && bus.instr_ready;
  assign last_byte = (state_q == S_FETCH) && (byte_cnt_q == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RST_STATE;
      pc_q          <= RESET_PC;
      byte_cnt_q    <= 2'd0;
      sh_q          <= 24'd0;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      byte_cnt_q    <= byte_cnt_d;
      sh_q          <= sh_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Redirect overrides every other transition, including a completing handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (byte_cnt_q == 2'd3) state_d = S_VALID;
      S_VALID: if (hs) state_d = (pc_inc < PC_LIMIT) ? S_FETCH : S_DONE;
      default: state_d = state_q;
    endcase
    if (bus.redirect) state_d = (redir_tgt < PC_LIMIT) ? S_FETCH : S_DONE;
  end

  always_comb begin
    pc_d          = pc_q;
    byte_cnt_d    = byte_cnt_q;
    sh_d          = sh_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    if (state_q == S_FETCH) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      if (last_byte) begin
        instr_d       = {sh_q, bus.mem_rdata};
        instr_pc_d    = pc_q;
        instr_valid_d = 1'b1;
      end else begin
        sh_d = {sh_q[15:0], bus.mem_rdata};
      end
    end

    if (hs) begin
      instr_valid_d = 1'b0;
      pc_d          = pc_inc;
    end

    // A redirect on the last byte suppresses the word; instr/instr_pc keep old values.
    if (bus.redirect) begin
      pc_d          = redir_tgt;
      byte_cnt_d    = 2'd0;
      sh_d          = 24'd0;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = 1'b0;
    end
  end

  always_comb begin
    bus.mem_addr    = pc_q + {30'd0, byte_cnt_q};
    bus.instr       = instr_q;
    bus.instr_pc    = instr_pc_q;
    bus.instr_valid = instr_valid_q;
    bus.done        = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: expected words are queued as fetch is
// steered and compared against every accepted handshake.
module tb_fetch_seq;

  logic clk;
  logic rst;
  fetch_if bus ();

  fetch_seq #(.RESET_PC(32'd0), .PC_LIMIT(32'd36)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [0:63];
  logic [63:0] sb_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_hs    = 0;

  always_comb bus.mem_rdata = mem[bus.mem_addr[5:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic put_word(input int addr, input logic [31:0] w);
    mem[addr]   = w[31:24];
    mem[addr+1] = w[23:16];
    mem[addr+2] = w[15:8];
    mem[addr+3] = w[7:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!bus.instr_valid && n < max) begin
      tick();
      n++;
    end
    if (!bus.instr_valid) chk("valid_timeout", 32'(bus.instr_valid), 32'd1);
  endtask

  // Handshake monitor: pop and compare one expected word per accepted transfer.
  always @(negedge clk) begin
    if (!rst && bus.instr_valid && bus.instr_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", bus.instr_pc, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("instr", bus.instr, e[63:32]);
        chk("instr_pc", bus.instr_pc, e[31:0]);
      end
      n_hs++;
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 7 + 3);
    put_word(0,  32'hFC20_0004);
    put_word(4,  32'hFC40_0003);
    put_word(8,  32'h0002_1020);
    put_word(24, 32'hAABB_CCDD);
    put_word(32, 32'h8C03_0020);

    rst = 1'b1;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    #12;
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_instr_pc", bus.instr_pc, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);

    sb_q.push_back({32'hFC20_0004, 32'd0});
    sb_q.push_back({32'hFC40_0003, 32'd4});
    sb_q.push_back({32'h0002_1020, 32'd8});
    rst = 1'b0;

    // First word with decode stalled for 7 cycles.
    tick(); chk("addr1", bus.mem_addr, 32'd1);
    tick(); chk("addr2", bus.mem_addr, 32'd2);
    tick(); chk("addr3", bus.mem_addr, 32'd3);
    chk("valid_early", 32'(bus.instr_valid), 32'd0);
    wait_valid(10, n);
    chk("lat_first", 32'(n), 32'd1);
    for (int i = 0; i < 7; i++) begin
      chk("stall_valid", 32'(bus.instr_valid), 32'd1);
      chk("stall_instr", bus.instr, 32'hFC20_0004);
      chk("stall_pc", bus.instr_pc, 32'd0);
      chk("stall_addr", bus.mem_addr, 32'd0);
      tick();
    end
    bus.instr_ready = 1'b1;
    tick();
    chk("hs0_valid", 32'(bus.instr_valid), 32'd0);
    chk("hs0_addr", bus.mem_addr, 32'd4);
    wait_valid(10, n);
    chk("lat_w4", 32'(n), 32'd4);
    tick();
    wait_valid(10, n);
    chk("lat_w8", 32'(n), 32'd4);

    // Redirect to 0x20 in the same cycle as the handshake of word @8.
    sb_q.push_back({32'h8C03_0020, 32'h20});
    bus.redirect = 1'b1; bus.redirect_pc = 32'h20;
    tick();
    bus.redirect = 1'b0;
    chk("rd20_addr", bus.mem_addr, 32'h20);
    chk("rd20_valid", 32'(bus.instr_valid), 32'd0);
    wait_valid(10, n);
    chk("lat_rd20", 32'(n), 32'd4);
    tick();

    // End of program reached: parked in DONE.
    for (int i = 0; i < 4; i++) begin
      chk("done_hi", 32'(bus.done), 32'd1);
      chk("done_valid", 32'(bus.instr_valid), 32'd0);
      chk("done_addr", bus.mem_addr, 32'h24);
      tick();
    end
    sb_q.push_back({32'hFC40_0003, 32'd4});
    bus.redirect = 1'b1; bus.redirect_pc = 32'd4;
    tick();
    bus.redirect = 1'b0;
    chk("undone", 32'(bus.done), 32'd0);
    chk("undone_addr", bus.mem_addr, 32'd4);
    wait_valid(10, n);
    chk("lat_rd4", 32'(n), 32'd4);

    // Redirect to unaligned 0x1A while byte_cnt=2 of word @8.
    tick();
    tick();
    tick();
    chk("partial_addr", bus.mem_addr, 32'hA);
    sb_q.push_back({32'hAABB_CCDD, 32'h18});
    bus.redirect = 1'b1; bus.redirect_pc = 32'h1A;
    tick();
    bus.redirect = 1'b0;
    chk("rd18_addr", bus.mem_addr, 32'h18);
    wait_valid(10, n);
    chk("lat_rd18", 32'(n), 32'd4);

    // Asynchronous reset between edges at byte_cnt=2 of word @0x1C.
    tick();
    tick();
    tick();
    chk("pre_rst_addr", bus.mem_addr, 32'h1E);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.instr_valid), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_instr", bus.instr, 32'd0);
    chk("arst_instr_pc", bus.instr_pc, 32'd0);
    chk("arst_addr", bus.mem_addr, 32'd0);
    sb_q.push_back({32'hFC20_0004, 32'd0});
    #3 rst = 1'b0;
    wait_valid(10, n);
    chk("lat_post_rst", 32'(n), 32'd4);
    tick();

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    chk("hs_count", 32'(n_hs), 32'd7);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
